// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues word fetches against queue credit, tags in-flight PCs, and flushes/retargets on redirect.
// Optional misaligned-redirect trap guarded by FETCH_MISALIGN_CHECK_EN.
module fetch_ctrl #(
    parameter int          XLEN            = 32,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            fetchEn,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemGnt,
    input  logic            imemRvalid,
    input  logic [31:0]     imemRdata,
    output logic            qPush,
    output logic [29:0]     qInstr,
    output logic [XLEN-6:0] qIAddr,
    output logic            qFlush,
    input  logic            qPop,
    output logic            fetchFault
);

    // state   | meaning
    // S_FETCH | issuing requests while credit allows
    // S_DRAIN | no issue; discarding stale responses after a redirect
    // S_FAULT | misaligned redirect trapped; waits for an aligned redirect

    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TW = XLEN - 5;
    localparam logic [XLEN-1:0] PC_RST = XLEN'(RESET_PC);

    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_FAULT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   stale_q, stale_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [PW-1:0]   wr_q, rd_q;
    logic [TW-1:0]   tag_q [MAX_OUTSTANDING];
    logic            fault_pend_q, fault_pend_d;

    logic            issue;
    logic            grant;
    logic            resp_live;
    logic            misalign;
    logic [CW-1:0]   pop_amt;
    logic            unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = |redirectPc[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign unused_bits = ^{imemRdata[1:0], redirectPc[1:0]};

    // occ+outstanding < DEPTH reserves a queue slot for every request in flight
    assign issue = (state_q == S_FETCH) && fetchEn
                && (outst_q < OW'(MAX_OUTSTANDING))
                && ((int'(occ_q) + int'(outst_q)) < DEPTH);

    assign imemReq   = issue && !redirect;
    assign imemAddr  = pc_q;
    assign grant     = imemReq && imemGnt;
    assign resp_live = imemRvalid && (stale_q == '0) && !redirect;

    assign qPush  = resp_live;
    assign qInstr = imemRdata[31:2];
    assign qIAddr = tag_q[rd_q];
    assign qFlush = redirect;

    assign pop_amt = (occ_q >= CW'(2)) ? CW'(2) : occ_q;

    always_comb begin
        pc_d         = pc_q;
        outst_d      = outst_q;
        stale_d      = stale_q;
        occ_d        = occ_q;
        state_d      = state_q;
        fault_pend_d = fault_pend_q;
        if (redirect) begin
            pc_d    = {redirectPc[XLEN-1:2], 2'b00};
            occ_d   = '0;
            outst_d = '0;
            // a response landing in the redirect cycle is one of the stale ones
            stale_d = stale_q + outst_q - (imemRvalid ? OW'(1) : OW'(0));
            fault_pend_d = misalign;
            if (stale_d != '0)
                state_d = S_DRAIN;
            else
                state_d = misalign ? S_FAULT : S_FETCH;
        end else begin
            if (grant)
                pc_d = pc_q + XLEN'(4);
            outst_d = outst_q + (grant ? OW'(1) : OW'(0)) - (resp_live ? OW'(1) : OW'(0));
            if (imemRvalid && (stale_q != '0))
                stale_d = stale_q - OW'(1);
            occ_d = occ_q + (resp_live ? CW'(1) : CW'(0)) - (qPop ? pop_amt : CW'(0));
            if ((state_q == S_DRAIN) && (stale_q == '0))
                state_d = fault_pend_q ? S_FAULT : S_FETCH;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;
    assign fetchFault = fault_q;
`else
    assign fetchFault = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_FETCH;
            pc_q         <= PC_RST;
            outst_q      <= '0;
            stale_q      <= '0;
            occ_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            fault_pend_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++)
                tag_q[i] <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            outst_q      <= outst_d;
            stale_q      <= stale_d;
            occ_q        <= occ_d;
            fault_pend_q <= fault_pend_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_q      <= (state_d == S_FAULT);
`endif
            if (redirect) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (grant) begin
                    tag_q[wr_q] <= pc_q[XLEN-4:2];
                    wr_q        <= ptr_inc(wr_q);
                end
                if (resp_live)
                    rd_q <= ptr_inc(rd_q);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle-latency in-order memory model that can be held off.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        fetchEn = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPc = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemRvalid = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        qPush;
    logic [29:0] qInstr;
    logic [26:0] qIAddr;
    logic        qFlush;
    logic        qPop = 1'b0;
    logic        fetchFault;

    fetch_ctrl dut (
        .clock(clock), .resetn(resetn), .fetchEn(fetchEn), .redirect(redirect),
        .redirectPc(redirectPc), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemGnt(imemGnt), .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .qPush(qPush), .qInstr(qInstr), .qIAddr(qIAddr), .qFlush(qFlush),
        .qPop(qPop), .fetchFault(fetchFault)
    );

    always #5 clock = ~clock;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          n_grant = 0;
    int          n_push = 0;
    int          g0, p0;
    logic [31:0] exp_addr = 32'h0;
    logic        mem_hold = 1'b0;
    logic [31:0] pend[$];
    logic        s_req, s_push, s_flush, s_fault;
    logic [31:0] s_addr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one clock: drive at negedge, sample combinational outputs 1ns later
    task automatic cyc(input logic en, input logic gnt, input logic pop,
                       input logic redir, input logic [31:0] rpc);
        logic        rv;
        logic [31:0] ra;
        logic [31:0] rw;
        ra = '0;
        @(negedge clock);
        fetchEn    = en;
        imemGnt    = gnt;
        qPop       = pop;
        redirect   = redir;
        redirectPc = rpc;
        rv = !mem_hold && (pend.size() > 0);
        if (rv) ra = pend.pop_front();
        rw = ~ra;
        imemRvalid = rv;
        imemRdata  = rv ? rw : 32'h0;
        #1;
        s_req   = imemReq;
        s_addr  = imemAddr;
        s_push  = qPush;
        s_flush = qFlush;
        s_fault = fetchFault;
        if (imemReq && gnt) begin
            chk("gnt_addr", imemAddr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            n_grant++;
            pend.push_back(imemAddr);
        end
        if (qPush) begin
            n_push++;
            chk("push_has_resp", rv, 1'b1);
            chk("push_iaddr", qIAddr, ra[28:2]);
            chk("push_instr", qInstr, rw[31:2]);
        end
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req", imemReq, 1'b0);
        chk("rst_addr", imemAddr, 32'h0);
        chk("rst_push", qPush, 1'b0);
        chk("rst_flush", qFlush, 1'b0);
        chk("rst_fault", fetchFault, 1'b0);
        @(negedge clock);
        resetn = 1'b1;

        // fill the queue: 0x0..0xC, then stall on credit
        repeat (8) cyc(1, 1, 0, 0, 0);
        chk("fill_grants", n_grant, 4);
        chk("fill_pushes", n_push, 4);
        chk("full_req", s_req, 1'b0);

        // one pop frees two slots -> 0x10, 0x14
        cyc(1, 1, 1, 0, 0);
        repeat (6) cyc(1, 1, 0, 0, 0);
        chk("pop_grants", n_grant, 6);
        chk("pop_pushes", n_push, 6);
        chk("pop_full_req", s_req, 1'b0);

        // grant held low: request and address stable, exactly one grant
        cyc(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk("wait_req", s_req, 1'b1);
            chk("wait_addr", s_addr, 32'h18);
        end
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("one_grant", n_grant, 7);
        chk("one_push", n_push, 7);

        // two outstanding, then redirect to 0x100
        mem_hold = 1'b1;
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("outst_grants", n_grant, 9);
        chk("outst_limit_req", s_req, 1'b0);
        cyc(1, 1, 0, 1, 32'h100);
        chk("redir_flush", s_flush, 1'b1);
        chk("redir_req", s_req, 1'b0);
        exp_addr = 32'h100;
        mem_hold = 1'b0;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("stale_no_push", n_push, 7);
        chk("drain_no_grant", n_grant, 9);
        repeat (10) cyc(1, 1, 0, 0, 0);
        chk("refill_grants", n_grant, 13);
        chk("refill_pushes", n_push, 11);
        chk("refill_full_req", s_req, 1'b0);

        // redirect coincident with a live response and a pop
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("pre_redir_grant", n_grant, 14);
        cyc(1, 1, 1, 1, 32'h300);
        chk("coinc_push", s_push, 1'b0);
        chk("coinc_flush", s_flush, 1'b1);
        chk("coinc_req", s_req, 1'b0);
        exp_addr = 32'h300;
        repeat (10) cyc(1, 1, 0, 0, 0);
        chk("coinc_grants", n_grant, 18);
        chk("coinc_pushes", n_push, 15);
        chk("coinc_full_req", s_req, 1'b0);

        // misaligned redirect
        g0 = n_grant;
        p0 = n_push;
        cyc(1, 1, 0, 1, 32'h102);
        chk("mis_flush", s_flush, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        cyc(1, 1, 0, 0, 0);
        chk("fault_set", s_fault, 1'b1);
        chk("fault_req", s_req, 1'b0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("fault_no_grant", n_grant, g0);
        chk("fault_hold", s_fault, 1'b1);
        cyc(1, 1, 0, 1, 32'h200);
        exp_addr = 32'h200;
        cyc(1, 1, 0, 0, 0);
        chk("fault_clear", s_fault, 1'b0);
        repeat (8) cyc(1, 1, 0, 0, 0);
        chk("fault_exit_grants", n_grant, g0 + 4);
        chk("fault_exit_pushes", n_push, p0 + 4);
`else
        exp_addr = 32'h100;
        repeat (9) cyc(1, 1, 0, 0, 0);
        chk("mask_fault", s_fault, 1'b0);
        chk("mask_grants", n_grant, g0 + 4);
        chk("mask_pushes", n_push, p0 + 4);
`endif

        // fetchEn low blocks issue
        cyc(0, 1, 1, 0, 0);
        g0 = n_grant;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk("en_off_req", s_req, 1'b0);
        end
        cyc(1, 1, 0, 0, 0);
        chk("en_on_grant", n_grant, g0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
